// File: rtl/gearbox_pkg.sv
// Shared constants and state encoding for the 67b->20b transmit gearbox controller.
package gearbox_pkg;

    localparam int IN_W      = 67;
    localparam int OUT_W     = 20;
    localparam int FILL_W    = 7;
    localparam int FRAME_LEN = 67;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } gb_state_e;

endpackage

// File: rtl/gearbox_tx_ctrl_if.sv
// Handshake and status bundle between the gearbox controller and its framer/datapath.
interface gearbox_tx_ctrl_if #(
    parameter int FILL_W = gearbox_pkg::FILL_W
);

    logic              ENABLE;
    logic              DATA_VALID;
    logic              CLR_ERR;
    logic              DATA_REQ;
    logic              LOAD_EN;
    logic [FILL_W-1:0] LOAD_OFFSET;
    logic              OUT_VALID;
    logic              FLUSH;
    logic [FILL_W-1:0] FILL_LEVEL;
    logic              FRAME_START;
    logic              UNDERFLOW;
    logic              ERR_STICKY;

    modport master (
        input  ENABLE,
        input  DATA_VALID,
        input  CLR_ERR,
        output DATA_REQ,
        output LOAD_EN,
        output LOAD_OFFSET,
        output OUT_VALID,
        output FLUSH,
        output FILL_LEVEL,
        output FRAME_START,
        output UNDERFLOW,
        output ERR_STICKY
    );

    modport slave (
        output ENABLE,
        output DATA_VALID,
        output CLR_ERR,
        input  DATA_REQ,
        input  LOAD_EN,
        input  LOAD_OFFSET,
        input  OUT_VALID,
        input  FLUSH,
        input  FILL_LEVEL,
        input  FRAME_START,
        input  UNDERFLOW,
        input  ERR_STICKY
    );

endinterface

// File: rtl/gearbox_tx_frame_cnt.sv
// Counts output words modulo the frame length and marks the first word of each frame.
module gearbox_tx_frame_cnt
    import gearbox_pkg::*;
#(
    parameter int LEN   = FRAME_LEN,
    parameter int CNT_W = $clog2(LEN)
) (
    input  logic USER_CLK,
    input  logic RESET,
    input  logic flush,
    input  logic out_valid,
    output logic frame_start
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (out_valid) begin
            cnt_q <= (cnt_q == CNT_W'(LEN - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign frame_start = out_valid && (cnt_q == '0);

endmodule

// File: rtl/gearbox_tx_ctrl.sv
// Fill-level controller for a 67b->20b shift-buffer gearbox: decides per cycle
// whether the datapath drains a 20-bit word and/or loads a new 67-bit word.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | disabled, buffer empty, no requests
//   ST_PRIME | enabled, waiting for the first word before draining
//   ST_RUN   | draining OUT_W bits per cycle, reloading whenever fill runs low
module gearbox_tx_ctrl
    import gearbox_pkg::*;
#(
    parameter int IN_W   = gearbox_pkg::IN_W,
    parameter int OUT_W  = gearbox_pkg::OUT_W,
    parameter int FILL_W = gearbox_pkg::FILL_W
) (
    input  logic                  USER_CLK,
    input  logic                  RESET,
    gearbox_tx_ctrl_if.master     bus
);

    gb_state_e         state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              underflow_q, err_q;

    logic              drain;
    logic [FILL_W-1:0] fill_after_drain;
    logic              data_req;
    logic              load;
    logic              flush;
    logic              underflow_set;
    logic              frame_start;

    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            fill_q      <= '0;
            underflow_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            underflow_q <= underflow_set;
            // A starvation event keeps the flag set even against a same-cycle clear.
            err_q       <= underflow_set | underflow_q | (err_q & ~bus.CLR_ERR);
        end
    end

    always_comb begin
        state_d          = state_q;
        drain            = 1'b0;
        fill_after_drain = fill_q;
        data_req         = 1'b0;
        load             = 1'b0;
        flush            = 1'b0;
        underflow_set    = 1'b0;
        fill_d           = fill_q;

        if (state_q == ST_RUN && bus.ENABLE && fill_q >= FILL_W'(OUT_W)) begin
            drain            = 1'b1;
            fill_after_drain = fill_q - FILL_W'(OUT_W);
        end

        flush         = !bus.ENABLE && (state_q != ST_IDLE);
        data_req      = bus.ENABLE && (state_q != ST_IDLE) &&
                        (fill_after_drain < FILL_W'(OUT_W));
        load          = data_req && bus.DATA_VALID;
        underflow_set = (state_q == ST_RUN) && data_req && !bus.DATA_VALID;

        if (flush) begin
            fill_d = '0;
        end else if (load) begin
            fill_d = fill_after_drain + FILL_W'(IN_W);
        end else begin
            fill_d = fill_after_drain;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.ENABLE) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!bus.ENABLE)  state_d = ST_IDLE;
                else if (load)    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.ENABLE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    gearbox_tx_frame_cnt #(
        .LEN   (FRAME_LEN)
    ) u_frame_cnt (
        .USER_CLK    (USER_CLK),
        .RESET       (RESET),
        .flush       (flush),
        .out_valid   (drain),
        .frame_start (frame_start)
    );

    assign bus.DATA_REQ    = data_req;
    assign bus.LOAD_EN     = load;
    assign bus.LOAD_OFFSET = fill_after_drain;
    assign bus.OUT_VALID   = drain;
    assign bus.FLUSH       = flush;
    assign bus.FILL_LEVEL  = fill_q;
    assign bus.FRAME_START = frame_start;
    assign bus.UNDERFLOW   = underflow_q;
    assign bus.ERR_STICKY  = err_q;

endmodule

// File: doc/gearbox_tx_ctrl.md
GEARBOX_TX_CTRL -- requirements
Module: gearbox_tx_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 67, meaning the width of the framed input word.
REQ-002 SHALL have parameter OUT_W, default 20, meaning the width of the serializer word output per cycle.
REQ-003 SHALL have parameter FILL_W, default 7, meaning the fill-counter width; it must hold values 0..(OUT_W-1+IN_W).
REQ-004 SHALL have port USER_CLK, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port ENABLE, input, 1 bit: run request; low = flush and idle.
REQ-007 SHALL have port DATA_VALID, input, 1 bit: upstream framer offers a 67-bit word this cycle.
REQ-008 SHALL have port DATA_REQ, output, 1 bit: controller will accept a word this cycle.
REQ-009 SHALL have port LOAD_EN, output, 1 bit: datapath writes the input word into the shift buffer.
REQ-010 SHALL have port LOAD_OFFSET, output, FILL_W bits: LSB bit position of the write.
REQ-011 SHALL have port OUT_VALID, output, 1 bit: datapath emits the low OUT_W buffer bits and shifts the buffer down by OUT_W.
REQ-012 SHALL have port FLUSH, output, 1 bit: datapath clears the buffer.
REQ-013 SHALL have port FILL_LEVEL, output, FILL_W bits: the fill register f.
REQ-014 SHALL have port FRAME_START, output, 1 bit: first output of each 67-output period.
REQ-015 SHALL have port UNDERFLOW, output, 1 bit: starvation pulse.
REQ-016 SHALL have port ERR_STICKY, output, 1 bit: latched underflow flag.
REQ-017 SHALL have port CLR_ERR, input, 1 bit: clears ERR_STICKY.

Function
REQ-018 SHALL implement states IDLE, PRIME and RUN, with IDLE as the reset state.
REQ-019 SHALL compute drain d = OUT_W if state is RUN, ENABLE=1 and f>=OUT_W; otherwise d=0.
REQ-020 SHALL drive OUT_VALID = (d != 0).
REQ-021 SHALL drive DATA_REQ = ENABLE && state!=IDLE && (f-d)<OUT_W, decoded from registers and ENABLE only.
REQ-022 SHALL drive LOAD_EN = DATA_REQ && DATA_VALID, combinationally in the same cycle; load size l = IN_W when LOAD_EN, else 0.
REQ-023 SHALL drive LOAD_OFFSET = f-d, valid whenever LOAD_EN=1.
REQ-024 SHALL update the fill as f_next = f-d+l; f never exceeds 86 and never goes below 0.
REQ-025 SHALL use these transitions:
- IDLE->PRIME when ENABLE=1.
- PRIME->RUN on LOAD_EN.
- PRIME or RUN -> IDLE when ENABLE=0.
REQ-026 SHALL, in a cycle where ENABLE=0 and state!=IDLE, force d=0 and l=0, pulse FLUSH (combinational, that cycle) and set f=0 at the next edge.
REQ-027 SHALL keep DATA_REQ, LOAD_EN and OUT_VALID low throughout IDLE, with f held at 0.
REQ-028 SHALL, when in RUN with f<OUT_W (stall), hold OUT_VALID low and DATA_REQ high until a load occurs.
REQ-029 SHALL register UNDERFLOW high for one cycle after any RUN cycle with DATA_REQ=1 and DATA_VALID=0.
REQ-030 SHALL set ERR_STICKY on UNDERFLOW and clear it on CLR_ERR; set wins when both occur together.
REQ-031 SHALL keep a modulo-67 counter of OUT_VALID cycles, cleared by FLUSH; FRAME_START = OUT_VALID && count==0.
REQ-032 SHALL, under continuous DATA_VALID, perform exactly 20 loads per 67 OUT_VALID cycles.

Reset
REQ-033 SHALL, on RESET high, immediately (asynchronously) set state to IDLE and zero f, the frame counter, UNDERFLOW and ERR_STICKY; all outputs read 0.
REQ-034 SHALL abandon any in-progress load or drain on reset mid-RUN; after release, operation restarts from PRIME with LOAD_OFFSET=0.

Structure
REQ-035 SHALL place IN_W, OUT_W, FILL_W, FRAME_LEN=67 and the state encoding in shared package gearbox_pkg.
REQ-036 SHALL implement the modulo-67 counter and FRAME_START as sub-module gearbox_tx_frame_cnt; all other logic stays in gearbox_tx_ctrl.

Verification
REQ-037 SHALL cover prime: ENABLE=1, DATA_VALID=1 from reset -> c0 PRIME, DATA_REQ=1, LOAD_OFFSET=0; c1 RUN, f=67, OUT_VALID=1; c2 f=47; c3 f=27, LOAD_EN=1, LOAD_OFFSET=7; c4 f=74.
REQ-038 SHALL cover steady rate: 670 cycles of continuous DATA_VALID in RUN -> 200 loads, 670 OUT_VALID, 10 FRAME_START, f always within 20..86.
REQ-039 SHALL cover underflow: DATA_VALID=0 on the requested cycle with f=27 -> next cycle f=7, OUT_VALID=0, UNDERFLOW=1, ERR_STICKY=1, DATA_REQ=1, LOAD_OFFSET=7; valid next cycle -> f=74, RUN resumes.
REQ-040 SHALL cover disable: ENABLE=0 at f=47 with DATA_VALID=1 -> FLUSH=1, LOAD_EN=0, OUT_VALID=0; next cycle IDLE, f=0; re-enable -> PRIME with offset 0.
REQ-041 SHALL cover reset: RESET pulsed mid-RUN between clock edges -> all outputs 0 before the next edge; ERR_STICKY=0.
REQ-042 SHALL cover the error flag: CLR_ERR coincident with an UNDERFLOW pulse -> ERR_STICKY remains 1; CLR_ERR alone next cycle -> 0.
